// File: rtl/maze_pkg.sv
// Shared maze definitions: tile-state codes, FSM states, colours and the
// power-on layout used to fill the tile map.
package maze_pkg;

  typedef enum logic [1:0] {
    TILE_PATH   = 2'b00,
    TILE_WALL   = 2'b01,
    TILE_PELLET = 2'b10,
    TILE_POWER  = 2'b11
  } tile_e;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_EAT_RD = 2'd2,
    ST_EAT_WR = 2'd3
  } state_e;

  localparam logic [11:0] COLOR_WALL   = 12'h000;
  localparam logic [11:0] COLOR_PATH   = 12'h8AF;
  localparam logic [11:0] COLOR_PELLET = 12'hFF0;
  localparam logic [11:0] COLOR_POWER  = 12'hFFF;
  localparam logic [11:0] COLOR_BLANK  = 12'h000;

  // Perimeter is wall, the four inner corners hold power pellets, the rest pellets.
  function automatic tile_e default_tile(input int row, input int col,
                                         input int rows, input int cols);
    tile_e t;
    if (row == 0 || col == 0 || row == rows - 1 || col == cols - 1) begin
      t = TILE_WALL;
    end else if ((row == 1 || row == rows - 2) && (col == 1 || col == cols - 2)) begin
      t = TILE_POWER;
    end else begin
      t = TILE_PELLET;
    end
    return t;
  endfunction

  function automatic logic in_square(input int off_row, input int off_col,
                                     input int tile_px, input int sq_px);
    int lo;
    lo = (tile_px - sq_px) / 2;
    return (off_row >= lo) && (off_row < lo + sq_px) &&
           (off_col >= lo) && (off_col < lo + sq_px);
  endfunction

  function automatic logic is_edible(input tile_e t);
    return (t == TILE_PELLET) || (t == TILE_POWER);
  endfunction

endpackage

// File: rtl/maze_tile_ram.sv
// Tile state storage: one read-only port for rendering and one read/write
// port for init/eat, both with registered (read-before-write) read data.
module maze_tile_ram #(
  parameter int DEPTH = 64,
  parameter int AW    = 6
) (
  input  logic          clk,
  input  logic [AW-1:0] rd_addr_i,
  output logic [1:0]    rd_data_o,
  input  logic [AW-1:0] rw_addr_i,
  input  logic          rw_we_i,
  input  logic [1:0]    rw_wdata_i,
  output logic [1:0]    rw_rdata_o
);

  logic [1:0] mem_q [DEPTH];
  logic [1:0] rd_data_q;
  logic [1:0] rw_rdata_q;

  always_ff @(posedge clk) begin
    if (rw_we_i) begin
      mem_q[rw_addr_i] <= rw_wdata_i;
    end
    rd_data_q  <= mem_q[rd_addr_i];
    rw_rdata_q <= mem_q[rw_addr_i];
  end

  assign rd_data_o  = rd_data_q;
  assign rw_rdata_o = rw_rdata_q;

endmodule

// File: rtl/maze_tile_map.sv
// Maze tile map: tile-state store with pellet bookkeeping, eat port and a
// 2-stage pixel render path. Define MAZE_BLINK_EN for blinking power pellets.
module maze_tile_map
  import maze_pkg::*;
#(
  parameter int ROWS      = 8,
  parameter int COLS      = 8,
  parameter int TILE_PX   = 60,
  parameter int PELLET_PX = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  input  logic [8:0]  p_row,
  input  logic [9:0]  p_col,
  output logic        color_valid,
  output logic [11:0] color_data,
  input  logic        eat_req,
  input  logic [5:0]  eat_row,
  input  logic [5:0]  eat_col,
  output logic        eat_ack,
  output logic [1:0]  eat_kind,
  output logic        ready,
  output logic [11:0] pellets_left,
  output logic        all_eaten,
  input  logic        frame_tick
);

  localparam int DEPTH = ROWS * COLS;
  localparam int AW    = $clog2(DEPTH);

  state_e      state_q, state_d;
  logic [5:0]  init_row_q, init_row_d, init_col_q, init_col_d;
  logic [11:0] pellets_q, pellets_d;
  logic        ready_q, ready_d, all_eaten_q, all_eaten_d, ack_q, ack_d;
  tile_e       kind_q, kind_d;
  logic [AW-1:0] eat_addr_q, eat_addr_d;
  logic        eat_oor_q, eat_oor_d;

  logic [AW-1:0] rd_addr_s, rw_addr_s, init_addr_s, req_addr_s;
  logic [1:0]  rd_data_s, rw_rdata_s, rw_wdata_s;
  logic        rw_we_s, init_last_s, req_oor_s, blink_s;
  tile_e       init_tile_s, rw_tile_s, rd_tile_s;

  int          pix_trow_s, pix_tcol_s;
  logic        pix_in_range_s;
  logic [9:0]  pix_orow_s, pix_ocol_s;
  logic        s1_valid_q, s1_inrange_q, s1_ready_q;
  logic [9:0]  s1_orow_q, s1_ocol_q;
  logic        in_pel_s, in_pwr_s;
  logic [11:0] color_d;
  logic        color_valid_q;
  logic [11:0] color_data_q;

  maze_tile_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk        (clk),
    .rd_addr_i  (rd_addr_s),
    .rd_data_o  (rd_data_s),
    .rw_addr_i  (rw_addr_s),
    .rw_we_i    (rw_we_s),
    .rw_wdata_i (rw_wdata_s),
    .rw_rdata_o (rw_rdata_s)
  );

`ifdef MAZE_BLINK_EN
  logic [4:0] frame_cnt_q;
  logic       blink_q;

  // Blink flag flips on every 16th frame tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= 5'd0;
      blink_q     <= 1'b1;
    end else if (frame_tick) begin
      frame_cnt_q <= frame_cnt_q + 5'd1;
      if (frame_cnt_q == 5'd15 || frame_cnt_q == 5'd31) begin
        blink_q <= ~blink_q;
      end
    end
  end
  assign blink_s = blink_q;
`else
  logic frame_tick_unused_s;
  assign frame_tick_unused_s = frame_tick;
  assign blink_s = 1'b1;
`endif

  assign init_last_s = (init_row_q == 6'(ROWS - 1)) && (init_col_q == 6'(COLS - 1));
  assign init_addr_s = AW'(int'(init_row_q) * COLS + int'(init_col_q));
  assign init_tile_s = default_tile(int'(init_row_q), int'(init_col_q), ROWS, COLS);
  assign req_oor_s   = (int'(eat_row) >= ROWS) || (int'(eat_col) >= COLS);
  assign req_addr_s  = req_oor_s ? {AW{1'b0}} : AW'(int'(eat_row) * COLS + int'(eat_col));
  assign rw_tile_s   = tile_e'(rw_rdata_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (init_last_s) state_d = ST_IDLE;   else state_d = ST_INIT;
      ST_IDLE:   if (eat_req)     state_d = ST_EAT_RD; else state_d = ST_IDLE;
      ST_EAT_RD: state_d = ST_EAT_WR;
      ST_EAT_WR: state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  // Read/write port steering; the eat write lands in EAT_WR, only for edible tiles.
  always_comb begin
    rw_addr_s  = eat_addr_q;
    rw_we_s    = 1'b0;
    rw_wdata_s = TILE_PATH;
    case (state_q)
      ST_INIT: begin
        rw_addr_s  = init_addr_s;
        rw_we_s    = 1'b1;
        rw_wdata_s = init_tile_s;
      end
      ST_IDLE:   rw_addr_s = req_addr_s;
      ST_EAT_RD: rw_addr_s = eat_addr_q;
      ST_EAT_WR: rw_we_s   = is_edible(kind_q);
      default:   rw_we_s   = 1'b0;
    endcase
  end

  always_comb begin
    init_row_d = init_row_q;
    init_col_d = init_col_q;
    pellets_d  = pellets_q;
    ready_d    = ready_q;
    ack_d      = 1'b0;
    kind_d     = kind_q;
    eat_addr_d = eat_addr_q;
    eat_oor_d  = eat_oor_q;
    case (state_q)
      ST_INIT: begin
        if (init_col_q == 6'(COLS - 1)) begin
          init_col_d = 6'd0;
          init_row_d = init_last_s ? 6'd0 : init_row_q + 6'd1;
        end else begin
          init_col_d = init_col_q + 6'd1;
        end
        if (is_edible(init_tile_s)) pellets_d = pellets_q + 12'd1;
        else                        pellets_d = pellets_q;
        if (init_last_s) ready_d = 1'b1;
        else             ready_d = 1'b0;
      end
      ST_IDLE: begin
        if (eat_req) begin
          eat_addr_d = req_addr_s;
          eat_oor_d  = req_oor_s;
        end else begin
          eat_addr_d = eat_addr_q;
        end
      end
      ST_EAT_RD: begin
        ack_d  = 1'b1;
        kind_d = eat_oor_q ? TILE_WALL : rw_tile_s;
        // Out-of-range eats report wall and never touch the count.
        if (!eat_oor_q && is_edible(rw_tile_s) && pellets_q != 12'd0) begin
          pellets_d = pellets_q - 12'd1;
        end else begin
          pellets_d = pellets_q;
        end
      end
      ST_EAT_WR: ack_d = 1'b0;
      default:   ack_d = 1'b0;
    endcase
    all_eaten_d = (pellets_d == 12'd0) && ready_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      init_row_q  <= 6'd0;
      init_col_q  <= 6'd0;
      pellets_q   <= 12'd0;
      ready_q     <= 1'b0;
      all_eaten_q <= 1'b0;
      ack_q       <= 1'b0;
      kind_q      <= TILE_PATH;
      eat_addr_q  <= {AW{1'b0}};
      eat_oor_q   <= 1'b0;
    end else begin
      init_row_q  <= init_row_d;
      init_col_q  <= init_col_d;
      pellets_q   <= pellets_d;
      ready_q     <= ready_d;
      all_eaten_q <= all_eaten_d;
      ack_q       <= ack_d;
      kind_q      <= kind_d;
      eat_addr_q  <= eat_addr_d;
      eat_oor_q   <= eat_oor_d;
    end
  end

  // Render stage 0: tile coordinates, in-tile offsets and the RAM read address.
  assign pix_trow_s     = int'(p_row) / TILE_PX;
  assign pix_tcol_s     = int'(p_col) / TILE_PX;
  assign pix_in_range_s = (pix_trow_s < ROWS) && (pix_tcol_s < COLS);
  assign pix_orow_s     = 10'(int'(p_row) % TILE_PX);
  assign pix_ocol_s     = 10'(int'(p_col) % TILE_PX);
  assign rd_addr_s      = pix_in_range_s ? AW'(pix_trow_s * COLS + pix_tcol_s) : {AW{1'b0}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_inrange_q <= 1'b0;
      s1_ready_q   <= 1'b0;
      s1_orow_q    <= 10'd0;
      s1_ocol_q    <= 10'd0;
    end else begin
      s1_valid_q   <= pix_valid;
      s1_inrange_q <= pix_in_range_s;
      s1_ready_q   <= ready_q;
      s1_orow_q    <= pix_orow_s;
      s1_ocol_q    <= pix_ocol_s;
    end
  end

  always_comb begin
    rd_tile_s = tile_e'(rd_data_s);
    in_pel_s  = in_square(int'(s1_orow_q), int'(s1_ocol_q), TILE_PX, PELLET_PX);
    in_pwr_s  = in_square(int'(s1_orow_q), int'(s1_ocol_q), TILE_PX, 2 * PELLET_PX);
    color_d   = COLOR_BLANK;
    if (!s1_valid_q || !s1_ready_q || !s1_inrange_q) begin
      color_d = COLOR_BLANK;
    end else begin
      case (rd_tile_s)
        TILE_WALL:   color_d = COLOR_WALL;
        TILE_PATH:   color_d = COLOR_PATH;
        TILE_PELLET: color_d = in_pel_s ? COLOR_PELLET : COLOR_PATH;
        TILE_POWER:  color_d = (blink_s && in_pwr_s) ? COLOR_POWER : COLOR_PATH;
        default:     color_d = COLOR_BLANK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      color_valid_q <= 1'b0;
      color_data_q  <= 12'h000;
    end else begin
      color_valid_q <= s1_valid_q;
      color_data_q  <= color_d;
    end
  end

  assign color_valid  = color_valid_q;
  assign color_data   = color_data_q;
  assign eat_ack      = ack_q;
  assign eat_kind     = kind_q;
  assign ready        = ready_q;
  assign pellets_left = pellets_q;
  assign all_eaten    = all_eaten_q;

endmodule
